// File: rtl/dac_serial_tx.sv
// Left-justified stereo serializer for an external audio DAC; bck is divided down from clk.
// Optional DAC_SER_OFFSET_BIN_EN: invert the sample MSB on capture (offset-binary to two's complement).
//
// state | meaning
// IDLE  | pins low, waiting for enable
// LOAD  | single handshake cycle before the first frame
// SHIFT | serializing slots 0..2W-1, frames chained back to back
module dac_serial_tx #(
  parameter int W    = 16,
  parameter int CDIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] sample,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic         underrun,
  output logic         frame_start,
  output logic         bck,
  output logic         lrck,
  output logic         sdata
);

  localparam int DW = (CDIV > 1) ? $clog2(CDIV) : 1;
  localparam int SW = $clog2(2 * W);
  localparam logic [DW-1:0] DIV_MAX  = DW'(CDIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'((CDIV > 1) ? CDIV - 2 : 0);
  localparam logic [SW-1:0] SLOT_MAX = SW'(2 * W - 1);
  localparam logic [SW-1:0] SLOT_R   = SW'(W);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div, div_nxt;
  logic [SW-1:0] slot, slot_nxt, slot_inc;
  logic [W-1:0]  hold, hold_nxt, sh, sh_nxt, sample_x, cap;
  logic          ready_nxt, under_nxt, fs_nxt, bck_nxt, lrck_nxt, sdata_nxt;
  logic          last_clk, pre_last, frame_end;

`ifdef DAC_SER_OFFSET_BIN_EN
  assign sample_x = {~sample[W-1], sample[W-2:0]};
`else
  assign sample_x = sample;
`endif

  assign cap       = sample_valid ? sample_x : hold;
  assign slot_inc  = slot + SW'(1);
  assign last_clk  = bck && (div == DIV_MAX);
  // the ready pulse is registered, so it is decided one clk before the slot's last clk
  assign pre_last  = (CDIV == 1) ? !bck : (bck && (div == DIV_PRE));
  assign frame_end = (state == SHIFT) && last_clk && (slot == SLOT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      div          <= '0;
      slot         <= '0;
      hold         <= '0;
      sh           <= '0;
      sample_ready <= 1'b0;
      underrun     <= 1'b0;
      frame_start  <= 1'b0;
      bck          <= 1'b0;
      lrck         <= 1'b0;
      sdata        <= 1'b0;
    end else begin
      state        <= state_nxt;
      div          <= div_nxt;
      slot         <= slot_nxt;
      hold         <= hold_nxt;
      sh           <= sh_nxt;
      sample_ready <= ready_nxt;
      underrun     <= under_nxt;
      frame_start  <= fs_nxt;
      bck          <= bck_nxt;
      lrck         <= lrck_nxt;
      sdata        <= sdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (frame_end && !sample_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div_nxt   = div;
    slot_nxt  = slot;
    hold_nxt  = hold;
    sh_nxt    = sh;
    ready_nxt = 1'b0;
    under_nxt = 1'b0;
    fs_nxt    = 1'b0;
    bck_nxt   = bck;
    lrck_nxt  = lrck;
    sdata_nxt = sdata;
    case (state)
      IDLE: begin
        div_nxt   = '0;
        slot_nxt  = '0;
        bck_nxt   = 1'b0;
        lrck_nxt  = 1'b0;
        sdata_nxt = 1'b0;
        if (enable) begin
          ready_nxt = 1'b1;
          under_nxt = !sample_valid;
        end
      end
      LOAD: begin
        hold_nxt  = cap;
        sh_nxt    = {cap[W-2:0], 1'b0};
        sdata_nxt = cap[W-1];
        fs_nxt    = 1'b1;
        div_nxt   = '0;
        slot_nxt  = '0;
        bck_nxt   = 1'b0;
        lrck_nxt  = 1'b0;
      end
      SHIFT: begin
        if (slot == SLOT_MAX && pre_last && enable) begin
          ready_nxt = 1'b1;
          under_nxt = !sample_valid;
        end
        if (!last_clk) begin
          if (div == DIV_MAX) begin
            div_nxt = '0;
            bck_nxt = 1'b1;
          end else begin
            div_nxt = div + DW'(1);
          end
        end else if (slot == SLOT_MAX) begin
          div_nxt  = '0;
          slot_nxt = '0;
          bck_nxt  = 1'b0;
          lrck_nxt = 1'b0;
          if (sample_ready) begin
            hold_nxt  = cap;
            sh_nxt    = {cap[W-2:0], 1'b0};
            sdata_nxt = cap[W-1];
            fs_nxt    = 1'b1;
          end else begin
            sdata_nxt = 1'b0;
          end
        end else begin
          div_nxt  = '0;
          bck_nxt  = 1'b0;
          slot_nxt = slot_inc;
          lrck_nxt = (slot_inc >= SLOT_R);
          // right channel restarts from the held word
          if (slot_inc == SLOT_R) begin
            sdata_nxt = hold[W-1];
            sh_nxt    = {hold[W-2:0], 1'b0};
          end else begin
            sdata_nxt = sh[W-1];
            sh_nxt    = {sh[W-2:0], 1'b0};
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Scoreboard bench for dac_serial_tx: the driver queues expected words, the monitor
// deserializes each frame and checks bck/lrck shape plus both channel words.
module tb_dac_serial_tx;

  logic        clk = 1'b0;
  logic        rst, enable, sample_valid;
  logic [15:0] sample;
  logic        sample_ready, underrun, frame_start, bck, lrck, sdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ready_cyc = 0;
  int frames_done = 0;
  logic [15:0] last_exp = 16'h0000;
  logic [15:0] sb[$];

  dac_serial_tx #(.W(16), .CDIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .underrun(underrun), .frame_start(frame_start),
    .bck(bck), .lrck(lrck), .sdata(sdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ser(input logic [15:0] w);
`ifdef DAC_SER_OFFSET_BIN_EN
    return w ^ 16'h8000;
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sample_ready) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // inputs must already hold w/v; returns just after the capture edge
  task automatic next_ready(input logic [15:0] w, input bit v, input bit chk_period);
    bit ok;
    logic [15:0] e;
    wait_ready(ok);
    check("ready_seen", {31'd0, ok}, 32'd1);
    if (ok) begin
      check("underrun_flag", {31'd0, underrun}, {31'd0, !v});
      if (chk_period) check("ready_period", cyc - last_ready_cyc, 32'd256);
      last_ready_cyc = cyc;
      e = v ? ser(w) : last_exp;
      last_exp = e;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: one frame = 32 slots x 8 clk, sampled on the falling clk edge
  initial begin
    forever begin
      @(negedge clk);
      if (frame_start === 1'b1 && rst === 1'b0) begin : frame
        logic [15:0] lw, rw, e;
        int bad_bck, bad_lr, bad_sd;
        bit aborted;
        logic cur;
        bad_bck = 0; bad_lr = 0; bad_sd = 0; aborted = 1'b0; cur = 1'b0;
        lw = '0; rw = '0;
        for (int i = 0; i < 256; i++) begin
          int s, c;
          if (i > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          s = i / 8;
          c = i % 8;
          if (bck !== (c >= 4)) bad_bck++;
          if (lrck !== (s >= 16)) bad_lr++;
          if (c == 0) begin
            cur = sdata;
            if (s < 16) lw[15-s] = sdata;
            else rw[31-s] = sdata;
          end else if (sdata !== cur) begin
            bad_sd++;
          end
        end
        if (aborted) begin
          sb.delete();
        end else if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: frame seen with no expected word (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("left_word", {16'd0, lw}, {16'd0, e});
          check("right_word", {16'd0, rw}, {16'd0, e});
          check("bck_shape_errs", bad_bck, 0);
          check("lrck_shape_errs", bad_lr, 0);
          check("sdata_stable_errs", bad_sd, 0);
          frames_done++;
        end
      end
    end
  end

  initial begin
    int nrdy;
    rst = 1'b1; enable = 1'b0; sample = '0; sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {26'd0, bck, lrck, sdata, sample_ready, underrun, frame_start}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_outs", {26'd0, bck, lrck, sdata, sample_ready, underrun, frame_start}, 32'd0);

    // basic frame 0xA5C3
    @(posedge clk); #1;
    sample = 16'hA5C3; sample_valid = 1'b1; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_latency", {31'd0, sample_ready}, 32'd1);
    check("underrun_first", {31'd0, underrun}, 32'd0);
    last_ready_cyc = cyc;
    last_exp = ser(16'hA5C3);
    sb.push_back(last_exp);
    @(posedge clk); #1 sample = 16'h0001;
    @(negedge clk);
    check("fs_latency", {31'd0, frame_start}, 32'd1);

    // continuous stream, then an underrun frame
    next_ready(16'h0001, 1'b1, 1'b1);
    sample = 16'hFFFE;
    next_ready(16'hFFFE, 1'b1, 1'b1);
    sample_valid = 1'b0; sample = 16'h5A5A;
    next_ready(16'h5A5A, 1'b0, 1'b1);
    sample_valid = 1'b1; sample = 16'h1234;
    next_ready(16'h1234, 1'b1, 1'b1);

    // enable drops in slot 5 of the 0x1234 frame
    @(negedge clk);
    check("fs_after_ready", {31'd0, frame_start}, 32'd1);
    nrdy = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (i == 42) enable = 1'b0;
      if (i < 256 && sample_ready) nrdy++;
      if (i == 256)
        check("idle_after_drop", {26'd0, bck, lrck, sdata, sample_ready, underrun, frame_start}, 32'd0);
    end
    check("no_ready_after_drop", nrdy, 0);

    // MSB handling: 0x8000
    @(posedge clk); #1;
    sample = 16'h8000; sample_valid = 1'b1; enable = 1'b1;
    next_ready(16'h8000, 1'b1, 1'b0);
    sample = 16'h4321;
    next_ready(16'h4321, 1'b1, 1'b1);

    // reset in slot 10 with enable held high
    @(negedge clk);
    repeat (80) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; sample = 16'h3C3C;
    @(negedge clk);
    check("rst_midframe_outs", {26'd0, bck, lrck, sdata, sample_ready, underrun, frame_start}, 32'd0);
    @(negedge clk);
    check("ready_after_rst", {31'd0, sample_ready}, 32'd1);
    if (sample_ready) begin
      check("underrun_after_rst", {31'd0, underrun}, 32'd0);
      sb.push_back(ser(16'h3C3C));
    end
    @(posedge clk); #1 enable = 1'b0;
    repeat (300) @(negedge clk);

    check("frames_compared", frames_done, 7);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
